// File: rtl/ascon_add_const.sv
// Ascon constant-addition layer (pC): XORs the round constant into the low byte of x2.
// Latency: 1 clock, registered output, one state per clock.
// Backpressure: none; valid_i is accepted every cycle, no ready.
//
// Ports:
//   clock_i   rising-edge clock
//   resetb_i  asynchronous active-low reset (clears add_o and valid_o)
//   valid_i   add_i/round_i carry a transfer this cycle
//   add_i     input state, word 0 = x0 .. word 4 = x4
//   round_i   round index 0..15; indices >= NB_ROUNDS add nothing
//   add_o     registered output state, held while valid_i is low
//   valid_o   add_o holds a fresh result this cycle
//   err_o     (only with ADD_CONST_RANGE_CHECK_EN) registered flag for a
//             valid transfer carrying an out-of-range round index
//
// Optional macro: ADD_CONST_RANGE_CHECK_EN adds the err_o range check.

package ascon_pack;
  typedef logic [4:0][63:0] type_state;
endpackage

module ascon_add_const
  import ascon_pack::*;
#(
  parameter int NB_ROUNDS = 12
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      valid_i,
  input  type_state add_i,
  input  logic [3:0] round_i,
  output type_state add_o,
  output logic      valid_o
`ifdef ADD_CONST_RANGE_CHECK_EN
  ,
  output logic      err_o
`endif
);

  logic      round_in_range;
  logic [7:0] round_const;
  type_state next_state;

  assign round_in_range = (int'(round_i) < NB_ROUNDS);

  // Table entry i is {~i, i} on nibbles, i.e. ((0xF - i) << 4) | i.
  // Out-of-range indices contribute nothing so the state passes through.
  always_comb begin
    round_const = 8'h00;
    if (round_in_range) begin
      round_const = {4'hF - round_i, round_i};
    end
  end

  // Only the low byte of x2 is touched; every other bit is a straight copy.
  always_comb begin
    next_state    = add_i;
    next_state[2] = add_i[2] ^ {56'h0, round_const};
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      add_o   <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        add_o <= next_state;
      end
    end
  end

`ifdef ADD_CONST_RANGE_CHECK_EN
  // Updates every cycle, so it drops back to 0 whenever valid_i is low.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= valid_i & ~round_in_range;
    end
  end
`endif

endmodule

// File: tb/tb_ascon_add_const.sv
// Self-checking bench for ascon_add_const: directed vectors plus randomized
// traffic compared against a behavioural model of the pC layer.
// Inputs are driven 1 time unit after the rising edge and outputs sampled there.

module tb_ascon_add_const;
  import ascon_pack::*;

  localparam int NB = 12;

  logic       clock_i;
  logic       resetb_i;
  logic       valid_i;
  type_state  add_i;
  logic [3:0] round_i;
  type_state  add_o;
  logic       valid_o;
`ifdef ADD_CONST_RANGE_CHECK_EN
  logic       err_o;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state (what add_o/valid_o/err_o should be now).
  type_state m_state;
  logic      m_vld;
  logic      m_err;

  ascon_add_const #(.NB_ROUNDS(NB)) dut (
    .clock_i (clock_i),
    .resetb_i(resetb_i),
    .valid_i (valid_i),
    .add_i   (add_i),
    .round_i (round_i),
    .add_o   (add_o),
    .valid_o (valid_o)
`ifdef ADD_CONST_RANGE_CHECK_EN
    ,
    .err_o   (err_o)
`endif
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // pC from its definition: constant for round r is (15-r)*16 + r, added
  // (XOR) into x2 for rounds below NB; anything else leaves the state alone.
  function automatic type_state ref_pc(input type_state s, input int r);
    type_state o;
    longint unsigned c;
    o = s;
    if (r < NB) begin
      c = longint'((15 - r) * 16 + r);
      o[2] = s[2] ^ c;
    end
    return o;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int k = 0; k < 5; k++) s[k] = {$urandom, $urandom};
    return s;
  endfunction

  // Drive one cycle, advance the model, compare everything.
  task automatic step(input logic v, input logic [3:0] r, input type_state s);
    valid_i = v;
    round_i = r;
    add_i   = s;
    @(posedge clock_i);
    #1;
    if (v) m_state = ref_pc(s, int'(r));
    m_vld = v;
    m_err = v && (int'(r) >= NB);
    check("valid_o", {319'b0, valid_o}, {319'b0, m_vld});
    check("add_o", add_o, m_state);
`ifdef ADD_CONST_RANGE_CHECK_EN
    check("err_o", {319'b0, err_o}, {319'b0, m_err});
`endif
  endtask

  type_state s;
  logic [63:0] x2_in  [5];
  logic [63:0] x2_exp [5];

  initial begin
    x2_in  = '{64'h076f27ad4d99d5e7, 64'h50117c5d8e989bd6, 64'heca11976718e1853,
               64'h67b186a49c0d9bfb, 64'h71a61481b4bdb7c3};
    x2_exp = '{64'h076f27ad4d99d560, 64'h50117c5d8e989bae, 64'heca11976718e183a,
               64'h67b186a49c0d9ba1, 64'h71a61481b4bdb788};
    m_state = '0;
    m_vld   = 1'b0;
    m_err   = 1'b0;

    // Power-on reset with live-looking inputs.
    resetb_i = 1'b0;
    valid_i  = 1'b1;
    round_i  = 4'd3;
    add_i    = rand_state();
    #1;
    check("por_add_o", add_o, '0);
    check("por_valid_o", {319'b0, valid_o}, 320'b0);
    @(posedge clock_i);
    #1;
    check("por_hold_add_o", add_o, '0);
    #2;
    resetb_i = 1'b1;
    @(posedge clock_i);
    #1;
    // That edge captured a transfer (valid_i=1, round 3): it is the first one after release.
    m_state = ref_pc(add_i, 3);
    m_vld   = 1'b1;
    m_err   = 1'b0;
    check("first_capture", add_o, m_state);

    // Round 6 vector.
    s[0] = 64'h80400c0600000000;
    s[1] = 64'h8a55114d1cb6a9a2;
    s[2] = 64'hbe263d4d7aecaaff;
    s[3] = 64'h4ed0ec0b98c529b7;
    s[4] = 64'hc8cddf37bcd0284a;
    step(1'b1, 4'd6, s);
    check("r6_x2", {256'b0, add_o[2]}, {256'b0, 64'hbe263d4d7aecaa69});
    check("r6_x0", {256'b0, add_o[0]}, {256'b0, 64'h80400c0600000000});
    check("r6_x4", {256'b0, add_o[4]}, {256'b0, 64'hc8cddf37bcd0284a});

    // Rounds 7..11 back to back.
    for (int i = 0; i < 5; i++) begin
      s = rand_state();
      s[2] = x2_in[i];
      step(1'b1, 4'(7 + i), s);
      check($sformatf("r%0d_x2", 7 + i), {256'b0, add_o[2]}, {256'b0, x2_exp[i]});
      check("b2b_valid", {319'b0, valid_o}, {319'b0, 1'b1});
    end

    // Round 0 on zero state, round 15 pass-through.
    step(1'b1, 4'd0, '0);
    check("r0_x2", {256'b0, add_o[2]}, {256'b0, 64'h00000000000000f0});
    s = rand_state();
    step(1'b1, 4'd15, s);
    check("r15_pass", add_o, s);
`ifdef ADD_CONST_RANGE_CHECK_EN
    check("r15_err", {319'b0, err_o}, {319'b0, 1'b1});
`endif

    // Hold: valid low with changing inputs.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'($urandom_range(0, 15)), rand_state());
      check("hold_x2", {256'b0, add_o[2]}, {256'b0, s[2]});
    end

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rand_state());
    end

    // Mid-cycle asynchronous reset after real data is in the register.
    step(1'b1, 4'd2, rand_state());
    valid_i = 1'b1;
    add_i   = rand_state();
    #3;
    resetb_i = 1'b0;
    #1;
    check("async_rst_add_o", add_o, '0);
    check("async_rst_valid_o", {319'b0, valid_o}, 320'b0);
    @(posedge clock_i);
    #1;
    check("rst_lost_input", add_o, '0);
    m_state = '0;
    m_vld   = 1'b0;
    m_err   = 1'b0;
    resetb_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 1) != 0, 4'($urandom_range(0, 15)), rand_state());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
